// File: rtl/stage_if_queue.sv
// Instruction-fetch stage with a DEPTH-entry fetch queue between instruction memory and ID.
// A redirect from MEM flushes the queue and discards any fetch still in flight.
module stage_if_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 1,
    parameter int                NUM_W    = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     redirect,
    input  logic [ADDR_W-1:0]        redirect_pc,
    output logic                     imem_req,
    output logic [ADDR_W-1:0]        imem_addr,
    input  logic                     imem_ack,
    input  logic [DATA_W-1:0]        imem_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_inst,
    output logic [ADDR_W-1:0]        out_next_pc,
    output logic [NUM_W-1:0]         out_inst_num,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int                PW      = $clog2(DEPTH);
    localparam int                CW      = PW + 1;
    localparam int                CX      = CW + 1;
    localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(PC_STEP);
    localparam logic [CW:0]       DEPTH_X = CX'(DEPTH);
    localparam logic [CW:0]       ONE_X   = CX'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DISCARD
    } state_t;

    state_t            state;
    state_t            state_d;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] req_addr;
    logic [ADDR_W-1:0] req_addr_d;
    logic [NUM_W-1:0]  seq;
    logic              push;
    logic              pop;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic [CW:0]       cnt_x;
    logic [CW:0]       pop_x;

    logic [DATA_W-1:0] mem_inst [DEPTH];
    logic [ADDR_W-1:0] mem_npc  [DEPTH];
    logic [NUM_W-1:0]  mem_num  [DEPTH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // A fetch is only started once a queue slot is guaranteed for its response,
    // so a push can never land on a full queue.
    always_comb begin
        state_d    = state;
        pc_d       = pc;
        req_addr_d = req_addr;
        push       = 1'b0;
        pop        = out_valid && out_ready;
        cnt_x      = {1'b0, count};
        pop_x      = CX'(pop);
        case (state)
            S_IDLE: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                end else if ((cnt_x - pop_x) < DEPTH_X) begin
                    req_addr_d = pc;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = imem_ack ? S_IDLE : S_DISCARD;
                end else if (imem_ack) begin
                    push = 1'b1;
                    pc_d = req_addr + STEP;
                    if ((cnt_x + ONE_X - pop_x) < DEPTH_X) begin
                        req_addr_d = req_addr + STEP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DISCARD: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                end
                if (imem_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
            seq      <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            pc       <= pc_d;
            req_addr <= req_addr_d;
            if (push) begin
                seq <= seq + NUM_W'(1);
            end
            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_inst[wr_ptr] <= imem_data;
            mem_npc[wr_ptr]  <= req_addr + STEP;
            mem_num[wr_ptr]  <= seq;
        end
    end

    // Head fields read as zero while the queue is empty so stale storage never leaks out.
    always_comb begin
        imem_req     = (state == S_WAIT) || (state == S_DISCARD);
        imem_addr    = req_addr;
        fifo_count   = count;
        out_valid    = (count != '0);
        out_inst     = out_valid ? mem_inst[rd_ptr] : '0;
        out_next_pc  = out_valid ? mem_npc[rd_ptr] : '0;
        out_inst_num = out_valid ? mem_num[rd_ptr] : '0;
    end

endmodule

// File: tb/tb_stage_if_queue.sv
// Directed bench for stage_if_queue: a vector table for streaming and back-pressure,
// then hand sequences for redirects, address/sequence wrap and mid-fetch reset.
module tb_stage_if_queue;

    logic        clock;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_next_pc;
    logic [3:0]  out_inst_num;
    logic [2:0]  fifo_count;

    int nvec;
    int nmis;

    typedef struct {
        logic        redirect;
        logic [31:0] rpc;
        logic        ack;
        logic        ready;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_npc;
        logic [3:0]  exp_num;
        logic [2:0]  exp_count;
    } vec_t;

    vec_t vecs [19];

    stage_if_queue #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .DEPTH    (4),
        .RESET_PC (32'h0),
        .PC_STEP  (1),
        .NUM_W    (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_data    (imem_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_inst     (out_inst),
        .out_next_pc  (out_next_pc),
        .out_inst_num (out_inst_num),
        .fifo_count   (fifo_count)
    );

    // Instruction memory returns a word that encodes its own address.
    assign imem_data = {16'hC0DE, imem_addr[15:0]};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic [31:0] rpc,
                                 input logic ack, input logic rdy);
        redirect    = r;
        redirect_pc = rpc;
        imem_ack    = ack;
        out_ready   = rdy;
    endtask

    task automatic checkOutput(input string name, input logic er, input logic [31:0] ea,
                               input logic ev, input logic [31:0] en,
                               input logic [3:0] eu, input logic [2:0] ec);
        logic [31:0] head_addr;
        logic [31:0] ei;
        head_addr = en - 32'd1;
        ei = ev ? {16'hC0DE, head_addr[15:0]} : 32'h0;
        nvec++;
        if (imem_req !== er || imem_addr !== ea || out_valid !== ev || out_next_pc !== en ||
            out_inst_num !== eu || fifo_count !== ec || out_inst !== ei) begin
            nmis++;
            $display("[TB] FAIL %s: got req=%b addr=%h valid=%b inst=%h npc=%h num=%0d count=%0d, want req=%b addr=%h valid=%b inst=%h npc=%h num=%0d count=%0d",
                     name, imem_req, imem_addr, out_valid, out_inst, out_next_pc, out_inst_num,
                     fifo_count, er, ea, ev, ei, en, eu, ec);
        end
    endtask

    task automatic doReset;
        reset = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        tick;
        tick;
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        nvec = 0;
        nmis = 0;
        reset = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);

        vecs[0]  = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'd0,  1'b0, 32'd0, 4'd0, 3'd0};
        vecs[1]  = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'd1,  1'b1, 32'd1, 4'd0, 3'd1};
        vecs[2]  = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'd2,  1'b1, 32'd2, 4'd1, 3'd1};
        vecs[3]  = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'd3,  1'b1, 32'd3, 4'd2, 3'd1};
        vecs[4]  = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'd4,  1'b1, 32'd3, 4'd2, 3'd2};
        vecs[5]  = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'd5,  1'b1, 32'd3, 4'd2, 3'd3};
        vecs[6]  = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'd5,  1'b1, 32'd3, 4'd2, 3'd4};
        for (int i = 7; i < 14; i++) begin
            vecs[i] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'd5, 1'b1, 32'd3, 4'd2, 3'd4};
        end
        vecs[14] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'd6,  1'b1, 32'd4, 4'd3, 3'd3};
        vecs[15] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'd7,  1'b1, 32'd5, 4'd4, 3'd3};
        vecs[16] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'd8,  1'b1, 32'd6, 4'd5, 3'd3};
        vecs[17] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'd9,  1'b1, 32'd7, 4'd6, 3'd3};
        vecs[18] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'd10, 1'b1, 32'd8, 4'd7, 3'd3};

        tick;
        tick;
        checkOutput("reset_state", 1'b0, 32'h0, 1'b0, 32'h0, 4'd0, 3'd0);
        reset = 1'b0;

        // Streaming with ack tied high, then ten stall cycles, then drain.
        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i].redirect, vecs[i].rpc, vecs[i].ack, vecs[i].ready);
            tick;
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_addr,
                        vecs[i].exp_valid, vecs[i].exp_npc, vecs[i].exp_num, vecs[i].exp_count);
        end

        // Redirect while a slow fetch is outstanding: its data must be dropped.
        doReset();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        tick;
        checkOutput("t3_wait", 1'b1, 32'h0, 1'b0, 32'h0, 4'd0, 3'd0);
        applyStimulus(1'b1, 32'h40, 1'b0, 1'b1);
        tick;
        checkOutput("t3_discard", 1'b1, 32'h0, 1'b0, 32'h0, 4'd0, 3'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        tick;
        checkOutput("t3_hold", 1'b1, 32'h0, 1'b0, 32'h0, 4'd0, 3'd0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        tick;
        checkOutput("t3_dropped", 1'b0, 32'h0, 1'b0, 32'h0, 4'd0, 3'd0);
        tick;
        checkOutput("t3_newreq", 1'b1, 32'h40, 1'b0, 32'h0, 4'd0, 3'd0);
        tick;
        checkOutput("t3_first", 1'b1, 32'h41, 1'b1, 32'h41, 4'd0, 3'd1);

        // Redirect coinciding with ack, with one entry already queued.
        doReset();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        tick;
        checkOutput("t4_req", 1'b1, 32'h0, 1'b0, 32'h0, 4'd0, 3'd0);
        tick;
        checkOutput("t4_push", 1'b1, 32'h1, 1'b1, 32'h1, 4'd0, 3'd1);
        applyStimulus(1'b1, 32'h80, 1'b1, 1'b0);
        tick;
        checkOutput("t4_flush", 1'b0, 32'h1, 1'b0, 32'h0, 4'd0, 3'd0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        tick;
        checkOutput("t4_newreq", 1'b1, 32'h80, 1'b0, 32'h0, 4'd0, 3'd0);
        tick;
        checkOutput("t4_first", 1'b1, 32'h81, 1'b1, 32'h81, 4'd1, 3'd1);

        // Address wrap across 2^32 and sequence-number wrap over 20 instructions.
        doReset();
        applyStimulus(1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1);
        tick;
        checkOutput("t5_redir", 1'b0, 32'h0, 1'b0, 32'h0, 4'd0, 3'd0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        tick;
        checkOutput("t5_req", 1'b1, 32'hFFFF_FFFE, 1'b0, 32'h0, 4'd0, 3'd0);
        tick;
        checkOutput("t5_a1", 1'b1, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 4'd0, 3'd1);
        for (int k = 1; k <= 20; k++) begin
            logic [31:0] ek;
            ek = 32'hFFFF_FFFF + 32'(k);
            tick;
            checkOutput($sformatf("t5_stream%0d", k), 1'b1, ek, 1'b1, ek, 4'(k), 3'd1);
        end

        // Asynchronous reset in the middle of a fetch with three entries queued.
        doReset();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        tick;
        tick;
        tick;
        tick;
        checkOutput("t6_three", 1'b1, 32'h3, 1'b1, 32'h1, 4'd0, 3'd3);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t6_async", 1'b0, 32'h0, 1'b0, 32'h0, 4'd0, 3'd0);
        tick;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        reset = 1'b0;
        tick;
        checkOutput("t6_addr", 1'b1, 32'h0, 1'b0, 32'h0, 4'd0, 3'd0);
        tick;
        checkOutput("t6_num", 1'b1, 32'h1, 1'b1, 32'h1, 4'd0, 3'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
